// File: rtl/fifo_param.sv
// fifo_param: synchronous FIFO with power-of-two depth, selectable
// registered or first-word-fall-through read, runtime almost-full/
// almost-empty thresholds, occupancy count and sticky error reporting.
module fifo_param #(
    parameter int DATA_W = 6,
    parameter int ADDR_W = 2,
    parameter int FWFT   = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              wr,
    input  logic              rd,
    input  logic [ADDR_W:0]   umbral_af,
    input  logic [ADDR_W:0]   umbral_ae,
    input  logic              err_clr,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic              pause,
    output logic              can_pop,
    output logic              wr_error,
    output logic              rd_error,
    output logic              error
);

    localparam int              DEPTH   = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W:0]   wr_ptr;
    logic [ADDR_W:0]   rd_ptr;
    logic              rd_acc;
    logic              wr_acc;
    logic              wr_err_nx;
    logic              rd_err_nx;
    logic [ADDR_W+1:0] af_sum;

    // Acceptance: a write into a full FIFO is allowed when a read frees a slot the same cycle.
    always_comb begin
        rd_acc    = rd && (count != '0);
        wr_acc    = wr && ((count != DEPTH_C) || rd_acc);
        wr_err_nx = wr && !wr_acc;
        rd_err_nx = rd && !rd_acc;
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array, written on accepted writes only (not reset).
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr[ADDR_W-1:0]] <= data_in;
    end

    // Error pulses and sticky error; a new error beats a simultaneous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_error <= 1'b0;
            rd_error <= 1'b0;
            error    <= 1'b0;
        end else begin
            wr_error <= wr_err_nx;
            rd_error <= rd_err_nx;
            error    <= (error && !err_clr) || wr_err_nx || rd_err_nx;
        end
    end

    // Status flags from registered count and live thresholds.
    // almost_full compares count + threshold against DEPTH in a wider
    // width so thresholds larger than DEPTH cannot underflow.
    always_comb begin
        af_sum       = {1'b0, count} + {1'b0, umbral_af};
        full         = (count == DEPTH_C);
        empty        = (count == '0);
        almost_full  = (af_sum >= (ADDR_W+2)'(DEPTH));
        almost_empty = (count <= umbral_ae);
        pause        = almost_full;
        can_pop      = !empty;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is presented combinationally while the FIFO holds data.
            always_comb begin
                data_out  = mem[rd_ptr[ADDR_W-1:0]];
                valid_out = (count != '0);
            end
        end else begin : g_reg
            // Registered read: one-cycle valid pulse per accepted read, data held otherwise.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    data_out  <= '0;
                    valid_out <= 1'b0;
                end else begin
                    valid_out <= rd_acc;
                    if (rd_acc) data_out <= mem[rd_ptr[ADDR_W-1:0]];
                end
            end
        end
    endgenerate

endmodule
